uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/upg_pkg.sv | 14 +
 rtl/uart_rx_core.sv | 52 +++++
 rtl/uart_prog_loader.sv | 103 ++++++++++
 tb/tb_uart_prog_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/upg_pkg.sv
// upg_pkg: parser state codes, segment target codes and segment size limit shared by the UART program loader
package upg_pkg;
  localparam logic [2:0] S_TGT    = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_CNT_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
  localparam logic [7:0] TGT_IMEM = 8'h00;
  localparam logic [7:0] TGT_DMEM = 8'h01;
  localparam logic [7:0] TGT_END  = 8'hFF;
  localparam logic [15:0] MAX_WORDS = 16'd16384;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-flop synchronizer and mid-bit sampling every DIV clocks
module uart_rx_core #(
  parameter int DIV = 78
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(DIV + 1);
  logic [1:0] sync;
  logic busy;
  logic [3:0] idx;
  logic [CW-1:0] cnt;
  logic rx_s;
  assign rx_s = sync[1];
  // bring the line into the clock domain, idling high
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], rx};
  // idx 0 = start check, 1..8 = data LSB first, 9 = stop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      idx <= '0;
      cnt <= '0;
      rx_byte <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      if (!busy) begin
        busy <= !rx_s;
        idx <= '0;
        cnt <= CW'(DIV / 2 - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= CW'(DIV - 1);
        idx <= idx + 1'b1;
        if (idx == 4'd0) busy <= !rx_s;
        else if (idx == 4'd9) begin
          busy <= 1'b0;
          byte_valid <= rx_s;
          frame_err <= !rx_s;
        end else rx_byte <= {rx_s, rx_byte[7:1]};
      end
    end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART segment parser writing 32-bit words to imem/dmem; UPG_CHECKSUM_EN adds per-segment checksum
module uart_prog_loader
  import upg_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 128_000
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);
  logic [7:0] rx_byte;
  logic byte_valid, frame_err;
  logic [2:0] state, after_seg;
  logic tgt;
  logic [7:0] cnt_lo;
  logic [15:0] n;
  logic [14:0] words_left;
  logic [13:0] wadr;
  logic [1:0] bidx;
  logic [23:0] sh;

  uart_rx_core #(.DIV(CLK_FREQ / BAUD)) u_rx (
    .clk(upg_clk_i),
    .rst(upg_rst_i),
    .rx(rx_i),
    .rx_byte(rx_byte),
    .byte_valid(byte_valid),
    .frame_err(frame_err)
  );

  assign n = {rx_byte, cnt_lo};
  assign upg_done_o = state == S_DONE;
  assign upg_err_o = state == S_ERR;

`ifdef UPG_CHECKSUM_EN
  logic [7:0] csum;
  assign after_seg = S_CSUM;
  // running sum restarts with each target byte
  always_ff @(posedge upg_clk_i or posedge upg_rst_i)
    if (upg_rst_i) csum <= '0;
    else if (byte_valid) csum <= state == S_TGT ? rx_byte : csum + rx_byte;
`else
  assign after_seg = S_TGT;
`endif

  // segment parser; partial words live only in sh and vanish on error or reset
  always_ff @(posedge upg_clk_i or posedge upg_rst_i)
    if (upg_rst_i) begin
      state <= S_TGT;
      tgt <= 1'b0;
      cnt_lo <= '0;
      words_left <= '0;
      wadr <= '0;
      bidx <= '0;
      sh <= '0;
      upg_wen_o <= 1'b0;
      upg_adr_o <= '0;
      upg_dat_o <= '0;
    end else begin
      upg_wen_o <= 1'b0;
      if (frame_err && state != S_DONE && state != S_ERR) state <= S_ERR;
      else if (byte_valid)
        case (state)
          S_TGT: begin
            tgt <= rx_byte[0];
            wadr <= '0;
            bidx <= '0;
            state <= rx_byte == TGT_END ? S_DONE :
                     (rx_byte == TGT_IMEM || rx_byte == TGT_DMEM) ? S_CNT_LO : S_ERR;
          end
          S_CNT_LO: begin
            cnt_lo <= rx_byte;
            state <= S_CNT_HI;
          end
          S_CNT_HI: begin
            words_left <= n[14:0];
            state <= n > MAX_WORDS ? S_ERR : n == '0 ? after_seg : S_DATA;
          end
          S_DATA: begin
            bidx <= bidx + 1'b1;
            sh <= {rx_byte, sh[23:8]};
            if (bidx == 2'd3) begin
              upg_wen_o <= 1'b1;
              upg_adr_o <= {tgt, wadr};
              upg_dat_o <= {rx_byte, sh};
              wadr <= wadr + 1'b1;
              words_left <= words_left - 1'b1;
              if (words_left == 15'd1) state <= after_seg;
            end
          end
`ifdef UPG_CHECKSUM_EN
          S_CSUM: state <= rx_byte == csum ? S_TGT : S_ERR;
`endif
          default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed table, corner sequences and random images against a byte-stream reference parser
module tb_uart_prog_loader;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD = 100_000;
  localparam int DIV = CLK_FREQ / BAUD;

  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic wen, done, err;
  logic [14:0] adr;
  logic [31:0] dat;
  int n_checks = 0, n_errors = 0;
  logic [46:0] wr_q[$], exp_q[$];
  logic m_done, m_err;

  typedef struct {
    string name;
    logic [7:0] b[$];
    int n_wr;
    logic [14:0] a0;
    logic [31:0] d0;
    logic [14:0] a1;
    logic [31:0] d1;
    logic done;
    logic err;
  } vec_t;
  vec_t vecs[5];

  uart_prog_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .upg_clk_i(clk),
    .upg_rst_i(rst),
    .rx_i(rx),
    .upg_wen_o(wen),
    .upg_adr_o(adr),
    .upg_dat_o(dat),
    .upg_done_o(done),
    .upg_err_o(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && wen) wr_q.push_back({adr, dat});

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    #1;
    check({nm, "_rst_out"}, {wen, done, err, adr, dat}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wr_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_all(input logic [7:0] bq[$]);
    foreach (bq[i]) send_byte(bq[i]);
    repeat (3 * DIV) @(negedge clk);
  endtask

  task automatic compare(input string nm);
    check({nm, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) check({nm, "_wr"}, 64'(wr_q[i]), 64'(exp_q[i]));
    check({nm, "_done"}, 64'(done), 64'(m_done));
    check({nm, "_err"}, 64'(err), 64'(m_err));
  endtask

  // reference: walk the byte stream segment by segment
  task automatic model(input logic [7:0] bq[$]);
    int i, n;
    logic [7:0] t, sum;
    logic [31:0] w;
    i = 0;
    exp_q.delete();
    m_done = 1'b0;
    m_err = 1'b0;
    forever begin
      if (i >= bq.size()) return;
      t = bq[i];
      i++;
      if (t == 8'hFF) begin m_done = 1'b1; return; end
      if (t > 8'h01) begin m_err = 1'b1; return; end
      if (i + 2 > bq.size()) return;
      n = int'({bq[i+1], bq[i]});
      sum = t + bq[i] + bq[i+1];
      i += 2;
      if (n > 16384) begin m_err = 1'b1; return; end
      for (int k = 0; k < n; k++) begin
        if (i + 4 > bq.size()) return;
        w = {bq[i+3], bq[i+2], bq[i+1], bq[i]};
        sum = sum + bq[i] + bq[i+1] + bq[i+2] + bq[i+3];
        i += 4;
        exp_q.push_back({t[0], 14'(k), w});
      end
`ifdef UPG_CHECKSUM_EN
      if (i >= bq.size()) return;
      if (bq[i] != sum) begin m_err = 1'b1; return; end
      i++;
`endif
    end
  endtask

  initial begin
    logic [7:0] img[$];
    logic [7:0] t, sum, nw, hi, d;
    vecs[0].name = "two_words";
`ifdef UPG_CHECKSUM_EN
    vecs[0].b = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4E, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`else
    vecs[0].b = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`endif
    vecs[0].n_wr = 2; vecs[0].a0 = 15'h0000; vecs[0].d0 = 32'h12345678;
    vecs[0].a1 = 15'h0001; vecs[0].d1 = 32'hDEADBEEF; vecs[0].done = 1'b1; vecs[0].err = 1'b0;
    vecs[1].name = "dmem_word";
`ifdef UPG_CHECKSUM_EN
    vecs[1].b = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h10, 8'hFF};
`else
    vecs[1].b = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF};
`endif
    vecs[1].n_wr = 1; vecs[1].a0 = 15'h4000; vecs[1].d0 = 32'hDDCCBBAA;
    vecs[1].a1 = '0; vecs[1].d1 = '0; vecs[1].done = 1'b1; vecs[1].err = 1'b0;
    vecs[2].name = "bad_target";
    vecs[2].b = '{8'h05, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    vecs[2].n_wr = 0; vecs[2].a0 = '0; vecs[2].d0 = '0;
    vecs[2].a1 = '0; vecs[2].d1 = '0; vecs[2].done = 1'b0; vecs[2].err = 1'b1;
    vecs[3].name = "count_too_big";
    vecs[3].b = '{8'h00, 8'h01, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF};
    vecs[3].n_wr = 0; vecs[3].a0 = '0; vecs[3].d0 = '0;
    vecs[3].a1 = '0; vecs[3].d1 = '0; vecs[3].done = 1'b0; vecs[3].err = 1'b1;
    vecs[4].name = "count_zero";
`ifdef UPG_CHECKSUM_EN
    vecs[4].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
`else
    vecs[4].b = '{8'h00, 8'h00, 8'h00, 8'hFF};
`endif
    vecs[4].n_wr = 0; vecs[4].a0 = '0; vecs[4].d0 = '0;
    vecs[4].a1 = '0; vecs[4].d1 = '0; vecs[4].done = 1'b1; vecs[4].err = 1'b0;

    foreach (vecs[v]) begin
      do_reset(vecs[v].name);
      send_all(vecs[v].b);
      exp_q.delete();
      if (vecs[v].n_wr > 0) exp_q.push_back({vecs[v].a0, vecs[v].d0});
      if (vecs[v].n_wr > 1) exp_q.push_back({vecs[v].a1, vecs[v].d1});
      m_done = vecs[v].done;
      m_err = vecs[v].err;
      compare(vecs[v].name);
    end

    do_reset("midword");
    send_all('{8'h00, 8'h02, 8'h00, 8'h78, 8'h56});
    check("midword_pre_nwr", 64'(wr_q.size()), 64'd0);
    do_reset("midword");
    send_all(vecs[0].b);
    exp_q.delete();
    exp_q.push_back({15'h0000, 32'h12345678});
    exp_q.push_back({15'h0001, 32'hDEADBEEF});
    m_done = 1'b1;
    m_err = 1'b0;
    compare("midword");

    do_reset("framing");
    send_all('{8'h00, 8'h01, 8'h00, 8'h11, 8'h22});
    send_byte(8'h33, 1'b0);
    send_all('{8'h44, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    exp_q.delete();
    m_done = 1'b0;
    m_err = 1'b1;
    compare("framing");

`ifdef UPG_CHECKSUM_EN
    do_reset("csum_ok");
    send_all('{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02});
    exp_q.delete();
    exp_q.push_back({15'h0000, 32'h00000001});
    m_done = 1'b0;
    m_err = 1'b0;
    compare("csum_ok");
    send_all('{8'hFF});
    m_done = 1'b1;
    compare("csum_ok_end");
    do_reset("csum_bad");
    send_all('{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03});
    m_done = 1'b0;
    m_err = 1'b1;
    compare("csum_bad");
`endif

    for (int it = 0; it < 8; it++) begin
      img.delete();
      for (int s = 0; s < $urandom_range(1, 3); s++) begin
        t = ($urandom_range(0, 15) == 0) ? 8'h07 : 8'($urandom_range(0, 1));
        nw = 8'($urandom_range(0, 2));
        hi = ($urandom_range(0, 11) == 0) ? 8'h41 : 8'h00;
        img.push_back(t);
        img.push_back(nw);
        img.push_back(hi);
        sum = t + nw + hi;
        if (hi == 8'h00)
          for (int k = 0; k < 4 * nw; k++) begin
            d = 8'($urandom);
            img.push_back(d);
            sum = sum + d;
          end
`ifdef UPG_CHECKSUM_EN
        img.push_back(($urandom_range(0, 7) == 0) ? sum + 8'd1 : sum);
`endif
      end
      if ($urandom_range(0, 3) != 0) img.push_back(8'hFF);
      do_reset("random");
      send_all(img);
      model(img);
      compare("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
